// File: rtl/ixc_osf1_evdrain.sv
// OSF1 event drain: buffers captured event records and presents them one at a time
// to the host transactor over req/ack, holding stop_req until every event is consumed.
module ixc_osf1_evdrain #(
    parameter int DW          = 32,
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                   uclk,
    input  logic                   rst_n,
    input  logic                   ev_push,
    input  logic [DW-1:0]          ev_data,
    output logic                   ev_full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   host_req,
    output logic [DW+7:0]          host_data,
    input  logic                   host_ack,
    output logic                   stop_req,
    output logic                   ovf,
    output logic                   timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [7:0]    TMO_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [7:0]        r_seq;
    logic [7:0]        r_tmo;
    logic              r_host_req;
    logic [DW+7:0]     r_host_data;
    logic              r_ovf;
    logic              r_timeout_err;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_tmo_hit;

    // Next-state decode plus push/pop qualification; a pop frees a slot for a same-cycle push.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tmo_hit   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != {CW{1'b0}}) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (host_ack) begin
                    w_state_nxt = ST_HOLD;
                end else if (r_tmo == TMO_LAST) begin
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_HOLD: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        w_push = ev_push && ((r_count != DEPTH_C) || w_pop);
        w_drop = ev_push && !w_push;
    end

    // FSM state register.
    always_ff @(posedge uclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Buffer storage; contents need no reset since count gates every read.
    always_ff @(posedge uclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ev_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge uclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Host-side record, sequence number, ack timer and sticky error flags.
    always_ff @(posedge uclk or negedge rst_n) begin
        if (!rst_n) begin
            r_host_req    <= 1'b0;
            r_host_data   <= {(DW+8){1'b0}};
            r_seq         <= 8'd0;
            r_tmo         <= 8'd0;
            r_ovf         <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_host_req <= (w_state_nxt == ST_REQ);
            if (w_pop) begin
                r_host_data <= {r_seq, r_mem[r_rd_ptr]};
                r_seq       <= r_seq + 8'd1;
                r_tmo       <= 8'd0;
            end else if ((r_state == ST_REQ) && !host_ack && !w_tmo_hit) begin
                r_tmo <= r_tmo + 8'd1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_tmo_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign ev_full     = (r_count == DEPTH_C);
    assign level       = r_count;
    assign host_req    = r_host_req;
    assign host_data   = r_host_data;
    assign stop_req    = (r_count != {CW{1'b0}}) | (r_state != ST_IDLE);
    assign ovf         = r_ovf;
    assign timeout_err = r_timeout_err;

endmodule
